// File: rtl/cru_strobe_sync_pkg.sv
// Shared types and constants for the TI-99 CRU write-strobe synchroniser.
// Address bits are numbered TI-style: [0:14], bit 0 is the MSB.
package cru_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW_CNT,
    FIRE,
    WAIT_HIGH
  } cru_state_e;

  localparam int ADDR_W = 15;

  // Top nibble of the CRU address that selects peripheral card space.
  localparam logic [3:0] CRU_SPACE = 4'b0001;

  // Field positions within addr[0:14].
  localparam int SPACE_FIRST = 0;
  localparam int SPACE_LAST  = 3;
  localparam int BASE_FIRST  = 4;
  localparam int BASE_LAST   = 7;
  localparam int IDX_FIRST   = 13;
  localparam int IDX_LAST    = 14;

endpackage

// File: rtl/cru_strobe_sync_if.sv
// TI-side CRU bus inputs plus the decoded single-bit write port.
// The master drives the TI bus and card base; the slave is the synchroniser.
interface cru_strobe_sync_if;
  import cru_pkg::*;

  logic [3:0]          cru_base;
  logic                ti_cru_clk;
  logic                ti_memen;
  logic [0:ADDR_W-1]   addr;
  logic                ti_cru_out;

  logic                wr_stb;
  logic [1:0]          wr_idx;
  logic                wr_data;
  logic                busy;

  modport master (
    output cru_base, ti_cru_clk, ti_memen, addr, ti_cru_out,
    input  wr_stb, wr_idx, wr_data, busy
  );

  modport slave (
    input  cru_base, ti_cru_clk, ti_memen, addr, ti_cru_out,
    output wr_stb, wr_idx, wr_data, busy
  );

endinterface

// File: rtl/cru_strobe_sync_sync_chain.sv
// Multi-flop synchroniser for asynchronous inputs, with a per-bit reset value
// so inactive-high strobes come out of reset looking idle.
module sync_chain #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking here would collapse
  // the chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cru_strobe_sync.sv
// Turns the asynchronous TI CRU write strobe into a filtered, single-clock
// write pulse with bit index and data for the downstream CRU bit register.
module cru_strobe_sync
  import cru_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2
) (
  input  logic                clk,
  input  logic                reset,
  cru_strobe_sync_if.slave    bus
);

  localparam int              CNT_W   = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN);

  // ---------------------------------------------------------------------------
  // Input synchronisers: strobes reset inactive (high), data resets to zero.
  // ---------------------------------------------------------------------------
  logic [1:0]        ctrl_s;
  logic [ADDR_W:0]   data_s;
  logic              cru_clk_s;
  logic              memen_s;
  logic [0:ADDR_W-1] addr_s;
  logic              cru_out_s;

  sync_chain #(
    .WIDTH   (2),
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (2'b11)
  ) u_sync_ctrl (
    .clk   (clk),
    .reset (reset),
    .d_i   ({bus.ti_cru_clk, bus.ti_memen}),
    .q_o   (ctrl_s)
  );

  sync_chain #(
    .WIDTH   (ADDR_W + 1),
    .DEPTH   (SYNC_STAGES),
    .RST_VAL ('0)
  ) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .d_i   ({bus.addr, bus.ti_cru_out}),
    .q_o   (data_s)
  );

  assign cru_clk_s = ctrl_s[1];
  assign memen_s   = ctrl_s[0];
  assign addr_s    = data_s[ADDR_W:1];
  assign cru_out_s = data_s[0];

  // addr[8:12] select bits within a card's CRU window this block never decodes.
  logic unused_addr;
  assign unused_addr = ^addr_s[8:12];

  // ---------------------------------------------------------------------------
  // Strobe filter FSM
  // ---------------------------------------------------------------------------
  cru_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_stb_q, wr_stb_d;
  logic [1:0]       wr_idx_q, wr_idx_d;
  logic             wr_data_q, wr_data_d;
  logic             capture;
  logic             hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  // cru_base is a static card strap, so it is compared unsynchronised at capture.
  assign hit = memen_s
            && (addr_s[SPACE_FIRST:SPACE_LAST] == CRU_SPACE)
            && (addr_s[BASE_FIRST:BASE_LAST]   == bus.cru_base);

  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path through the
    // case can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    capture   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!cru_clk_s) begin
          cnt_d = CNT_W'(1);
          if (CNT_W'(1) >= CNT_MAX) capture = 1'b1;
          else                      state_d = LOW_CNT;
        end
      end
      LOW_CNT: begin
        if (cru_clk_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == CNT_MAX) capture = 1'b1;
        end
      end
      FIRE: begin
        state_d = WAIT_HIGH;
        cnt_d   = '0;
      end
      WAIT_HIGH: begin
        if (!cru_clk_s) begin
          cnt_d = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == CNT_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered on the edge that enters FIRE, so they are valid
    // for exactly the FIRE cycle and a reset on that edge suppresses the pulse.
    if (capture) begin
      state_d   = FIRE;
      wr_stb_d  = hit;
      wr_idx_d  = addr_s[IDX_FIRST:IDX_LAST];
      wr_data_d = cru_out_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= 2'b00;
      wr_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_idx  = wr_idx_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_cru_strobe_sync.sv
// Directed bench for cru_strobe_sync: inputs change 1 time unit after a falling
// clock edge, outputs are sampled on falling edges by a pulse/busy monitor.
module tb_cru_strobe_sync;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 2;
  localparam int LAT         = SYNC_STAGES + FILT_LEN;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  int cyc      = 0;
  int fall_cyc = 0;
  int pulses   = 0;
  int last_lat = -1;
  int busy_cnt = 0;
  logic [1:0] idx_log [$];
  logic       data_log [$];

  cru_strobe_sync_if bus ();

  cru_strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.wr_stb === 1'b1) begin
      pulses   = pulses + 1;
      last_lat = cyc - fall_cyc;
      idx_log.push_back(bus.wr_idx);
      data_log.push_back(bus.wr_data);
    end
    if (bus.busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic clear_mon();
    pulses   = 0;
    busy_cnt = 0;
    last_lat = -1;
    idx_log.delete();
    data_log.delete();
  endtask

  task automatic set_bus(input logic [3:0] base, input logic [14:0] a,
                         input logic memen, input logic dout);
    bus.cru_base   = base;
    bus.addr       = a;
    bus.ti_memen   = memen;
    bus.ti_cru_out = dout;
  endtask

  // Strobe low for low_cyc clocks, then high for high_cyc+1 clocks before the
  // next call can pull it low again.
  task automatic cru_cycle(input int low_cyc, input int high_cyc);
    @(negedge clk); #1;
    bus.ti_cru_clk = 1'b0;
    fall_cyc = cyc;
    repeat (low_cyc) @(negedge clk);
    #1 bus.ti_cru_clk = 1'b1;
    repeat (high_cyc) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ti_cru_clk = 1'b1;
    set_bus(4'h0, 15'h0000, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (bus.wr_stb !== 1'b0) begin failures++; $display("FAIL reset_wr_stb: got %b expected 0", bus.wr_stb); end
    checks++; if (bus.wr_idx !== 2'b00) begin failures++; $display("FAIL reset_wr_idx: got %b expected 00", bus.wr_idx); end
    checks++; if (bus.wr_data !== 1'b0) begin failures++; $display("FAIL reset_wr_data: got %b expected 0", bus.wr_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    #1 reset = 1'b0;
    clear_mon();
    repeat (4) @(negedge clk);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
    checks++; if (busy_cnt !== 0) begin failures++; $display("FAIL idle_busy: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_basic_write();
    set_bus(4'h0, 15'h0801, 1'b1, 1'b1);
    clear_mon();
    cru_cycle(10, 8);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
    checks++; if (idx_log.size() == 0 || idx_log[0] !== 2'd1) begin failures++; $display("FAIL basic_idx: got %0d entries first %b expected 01", idx_log.size(), (idx_log.size() == 0) ? 2'bxx : idx_log[0]); end
    checks++; if (data_log.size() == 0 || data_log[0] !== 1'b1) begin failures++; $display("FAIL basic_data: got %0d entries expected data 1", data_log.size()); end
    checks++; if (last_lat !== LAT) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", last_lat, LAT); end
    checks++; if (busy_cnt !== 11) begin failures++; $display("FAIL basic_busy_len: got %0d expected 11", busy_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_idle_after: busy %b expected 0", bus.busy); end
  endtask

  task automatic test_glitch();
    set_bus(4'h0, 15'h0801, 1'b1, 1'b1);
    clear_mon();
    cru_cycle(1, 8);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
    checks++; if (busy_cnt !== 1) begin failures++; $display("FAIL glitch_busy_len: got %0d expected 1", busy_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL glitch_idle_after: busy %b expected 0", bus.busy); end
  endtask

  task automatic test_base_mismatch();
    set_bus(4'h2, 15'h0803, 1'b1, 1'b1);
    clear_mon();
    cru_cycle(10, 8);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL base_mismatch_pulses: got %0d expected 0", pulses); end
    checks++; if (busy_cnt !== 11) begin failures++; $display("FAIL base_mismatch_busy_len: got %0d expected 11", busy_cnt); end
    checks++; if (bus.wr_idx !== 2'd3) begin failures++; $display("FAIL base_mismatch_idx: got %b expected 11", bus.wr_idx); end
  endtask

  task automatic test_memen_low();
    set_bus(4'h0, 15'h0801, 1'b0, 1'b1);
    clear_mon();
    cru_cycle(10, 8);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL memen_low_pulses: got %0d expected 0", pulses); end
    checks++; if (busy_cnt !== 11) begin failures++; $display("FAIL memen_low_busy_len: got %0d expected 11", busy_cnt); end
  endtask

  task automatic test_base_change();
    set_bus(4'h2, 15'h0802, 1'b1, 1'b0);
    clear_mon();
    @(negedge clk); #1;
    bus.ti_cru_clk = 1'b0;
    fall_cyc = cyc;
    @(negedge clk); #1;
    bus.cru_base = 4'h0;
    repeat (9) @(negedge clk);
    #1 bus.ti_cru_clk = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL base_change_pulses: got %0d expected 1", pulses); end
    checks++; if (idx_log.size() == 0 || idx_log[0] !== 2'd2) begin failures++; $display("FAIL base_change_idx: got %0d entries expected idx 10", idx_log.size()); end
    checks++; if (data_log.size() == 0 || data_log[0] !== 1'b0) begin failures++; $display("FAIL base_change_data: got %0d entries expected data 0", data_log.size()); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got_idx;
    logic       got_data;
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      set_bus(4'h0, 15'h0800 | 15'(i), 1'b1, 1'b1);
      cru_cycle(6, 3);
    end
    repeat (8) @(negedge clk);
    checks++; if (pulses !== 4) begin failures++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
    for (int i = 0; i < 4; i++) begin
      got_idx  = (i < idx_log.size())  ? idx_log[i]  : 2'bxx;
      got_data = (i < data_log.size()) ? data_log[i] : 1'bx;
      checks++; if (got_idx !== 2'(i)) begin failures++; $display("FAIL b2b_idx[%0d]: got %b expected %0d", i, got_idx, i); end
      checks++; if (got_data !== 1'b1) begin failures++; $display("FAIL b2b_data[%0d]: got %b expected 1", i, got_data); end
    end
  endtask

  task automatic test_reset_in_fire();
    set_bus(4'h0, 15'h0801, 1'b1, 1'b1);
    clear_mon();
    @(negedge clk); #1;
    bus.ti_cru_clk = 1'b0;
    fall_cyc = cyc;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.wr_stb !== 1'b0) begin failures++; $display("FAIL fire_reset_wr_stb: got %b expected 0", bus.wr_stb); end
    checks++; if (bus.wr_idx !== 2'b00) begin failures++; $display("FAIL fire_reset_wr_idx: got %b expected 00", bus.wr_idx); end
    checks++; if (bus.wr_data !== 1'b0) begin failures++; $display("FAIL fire_reset_wr_data: got %b expected 0", bus.wr_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL fire_reset_busy: got %b expected 0", bus.busy); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL fire_reset_pulses: got %0d expected 0", pulses); end
    // Strobe is still low: after the synchronisers settle it is a fresh edge.
    #1 reset = 1'b0;
    fall_cyc = cyc;
    repeat (8) @(negedge clk);
    #1 bus.ti_cru_clk = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL post_reset_pulses: got %0d expected 1", pulses); end
    checks++; if (last_lat !== LAT) begin failures++; $display("FAIL post_reset_latency: got %0d expected %0d", last_lat, LAT); end
    checks++; if (bus.wr_idx !== 2'd1) begin failures++; $display("FAIL post_reset_idx: got %b expected 01", bus.wr_idx); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_glitch();
    test_base_mismatch();
    test_memen_low();
    test_base_change();
    test_back_to_back();
    test_reset_in_fire();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
